commit_trace_buffer: RTL and testbench
======================================

Name: commit_trace_buffer

Overview:
- Retirement-side trace capture unit; sits directly downstream of the MEM/WB boundary and memory-stage signals of the pipelined cpu.
- Each cycle, classifies the retiring event as REG write, STORE, HALT or NOP/branch, and tags it with an instruction number.
- Queues the record in a FIFO that a trace sink drains through a valid/ready handshake.
- Also maintains cycle and instruction counters, a cycle-limit watchdog, and overflow accounting.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 2.
MAX_CYCLES, 100000, watchdog limit on counted cycles; 32-bit value.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
commit_valid  in  1  a retirement slot is presented this cycle; 0 = pipeline bubble.
commit_pc  in  16  PC of the retiring instruction.
wb_regwrite  in  1  MEM/WB register write enable.
wb_reg_rd  in  4  destination register.
wb_data  in  16  register write data.
mem_read  in  1  retiring instruction is a load.
mem_write  in  1  retiring instruction is a store.
mem_addr  in  16  memory address (EX/MEM ALU result).
mem_wdata  in  16  store data.
hlt  in  1  HLT has reached retirement.
rec_ready  in  1  sink accepts the head record.
rec_valid  out  1  FIFO non-empty.
rec_kind  out  2  00 NOP, 01 REG, 10 STORE, 11 HALT.
rec_load  out  1  REG record produced by a load.
rec_inum  out  16  instruction number of the record (low 16 bits).
rec_pc  out  16  PC.
rec_reg  out  4  destination register (REG records), else 0.
rec_a  out  16  REG: write value; STORE: address; else 0.
rec_b  out  16  REG with load: address; STORE: store data; else 0.
cycle_count  out  32  cycles since reset release.
inst_count  out  32  commits captured (accepted or dropped).
drop_count  out  16  records lost to FIFO full; saturates at 0xFFFF.
overflow  out  1  sticky; set on first drop.
halted  out  1  sticky; HALT seen.
timeout  out  1  sticky; watchdog fired.

Behaviour:
- Reset (rst=1 at an edge): FIFO emptied, all counters 0, overflow/halted/timeout 0.
  - Record outputs read as 0 while empty.
  - Reset wins over every simultaneous event, including mid-drain.
- Capture is active when halted=0 and timeout=0. When inactive: no pushes, counters frozen, draining continues.
- cycle_count increments every active cycle.
  - When cycle_count == MAX_CYCLES-1 at an edge, the increment reaches MAX_CYCLES and timeout sets at that same edge.
- Classification on an active cycle with commit_valid=1, strict priority:
  - wb_regwrite -> REG. rec_load = mem_read; rec_b = mem_addr when rec_load=1, else 0.
  - else hlt -> HALT.
  - else mem_write -> STORE.
  - else -> NOP.
- On each such commit, inst_count increments.
  - rec_inum = inst_count value before the increment, so the first commit has inum 0.
- HALT commit: halted sets at the same edge. Later commit_valid inputs are ignored.
- Latency: a record pushed at edge N is visible on the rec_* outputs from edge N onward, if the FIFO was empty.
- FIFO is show-ahead: the rec_* outputs reflect the head entry combinationally from storage. No empty bypass.
- Pop occurs when rec_valid & rec_ready.
- Full with a push and no pop: record dropped, drop_count increments (saturating), overflow sets. inst_count still increments.
- Full with a push and a pop at the same edge: both happen; no drop.
- Empty with rec_ready=1: no pop, pointers unchanged.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full/empty are decided by the MSB-differ/equal compare.

Test Plan:
- Reset, then commit REG (pc 0x0000, r3 = 0x1234) with rec_ready=0 -> next cycle rec_valid=1, kind=01, inum=0, reg=3, a=0x1234; inst_count=1.
- Load commit (wb_regwrite=1, mem_read=1, mem_addr=0x0040, r5 = 0xBEEF) -> kind=01, load=1, a=0xBEEF, b=0x0040. Then a store commit (addr 0x0042, data 0x00AA) -> kind=10, a=0x0042, b=0x00AA, inum=1.
- With rec_ready=0, push 20 commits into DEPTH=16 -> 16 held, drop_count=4, overflow=1, inst_count=20. Drain -> inums 0..15 in order. Also push and pop at the same edge while full -> no drop.
- HALT at the 3rd commit, followed by further REG commits -> halted=1, exactly 3 records, inst_count=3, cycle_count frozen.
- MAX_CYCLES=10, no halt -> timeout=1 with cycle_count=10 and capture stopped. Assert rst mid-drain -> all outputs 0 at the next edge.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
// Retirement-side trace capture. Each retiring slot is classified as
// REG / STORE / HALT / NOP, tagged with an instruction number and queued
// in a show-ahead FIFO that a trace sink drains with rec_valid/rec_ready.
// Also keeps cycle/instruction counters, a cycle watchdog and drop stats.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   commit_valid, commit_pc       retirement slot and its PC
//   wb_regwrite, wb_reg_rd, wb_data   MEM/WB register write
//   mem_read, mem_write, mem_addr, mem_wdata   memory-stage info
//   hlt                           HLT has reached retirement
//   rec_ready / rec_valid         sink handshake
//   rec_kind, rec_load, rec_inum, rec_pc, rec_reg, rec_a, rec_b   head record
//   cycle_count, inst_count, drop_count   statistics
//   overflow, halted, timeout     sticky status flags
module commit_trace_buffer #(
  parameter int          DEPTH      = 16,
  parameter logic [31:0] MAX_CYCLES = 32'd100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [15:0] commit_pc,
  input  logic        wb_regwrite,
  input  logic [3:0]  wb_reg_rd,
  input  logic [15:0] wb_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  input  logic        hlt,
  input  logic        rec_ready,
  output logic        rec_valid,
  output logic [1:0]  rec_kind,
  output logic        rec_load,
  output logic [15:0] rec_inum,
  output logic [15:0] rec_pc,
  output logic [3:0]  rec_reg,
  output logic [15:0] rec_a,
  output logic [15:0] rec_b,
  output logic [31:0] cycle_count,
  output logic [31:0] inst_count,
  output logic [15:0] drop_count,
  output logic        overflow,
  output logic        halted,
  output logic        timeout
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] KIND_NOP   = 2'b00;
  localparam logic [1:0] KIND_REG   = 2'b01;
  localparam logic [1:0] KIND_STORE = 2'b10;
  localparam logic [1:0] KIND_HALT  = 2'b11;

  typedef struct packed {
    logic [1:0]  kind;
    logic        load;
    logic [15:0] inum;
    logic [15:0] pc;
    logic [3:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
  } rec_t;

  rec_t        mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [31:0] cycle_q, cycle_d, inst_q, inst_d;
  logic [15:0] drop_q, drop_d;
  logic        ovf_q, ovf_d, halt_q, halt_d, to_q, to_d;

  logic active, empty, full, pop, commit, push, drop;
  rec_t new_rec, head;

  assign active = ~halt_q & ~to_q;
  assign empty  = (wptr_q == rptr_q);
  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop    = ~empty & rec_ready;
  assign commit = active & commit_valid;
  // A pop at the same edge frees the slot being written, so full+pop still pushes.
  assign push   = commit & (~full | pop);
  assign drop   = commit & full & ~pop;

  // Record classification: regwrite beats hlt beats store.
  always_comb begin
    new_rec      = '0;
    new_rec.pc   = commit_pc;
    new_rec.inum = inst_q[15:0];
    if (wb_regwrite) begin
      new_rec.kind = KIND_REG;
      new_rec.load = mem_read;
      new_rec.rd   = wb_reg_rd;
      new_rec.a    = wb_data;
      new_rec.b    = mem_read ? mem_addr : 16'h0;
    end else if (hlt) begin
      new_rec.kind = KIND_HALT;
    end else if (mem_write) begin
      new_rec.kind = KIND_STORE;
      new_rec.a    = mem_addr;
      new_rec.b    = mem_wdata;
    end else begin
      new_rec.kind = KIND_NOP;
    end
  end

  always_comb begin
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
    cycle_d = active ? cycle_q + 32'd1 : cycle_q;
    inst_d  = commit ? inst_q + 32'd1 : inst_q;
    drop_d  = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    ovf_d   = ovf_q | drop;
    halt_d  = halt_q | (commit && new_rec.kind == KIND_HALT);
    // Timeout lands on the same edge the counter reaches MAX_CYCLES.
    to_d    = to_q | (active && cycle_q == MAX_CYCLES - 32'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cycle_q <= '0;
      inst_q  <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
      halt_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cycle_q <= cycle_d;
      inst_q  <= inst_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      halt_q  <= halt_d;
      to_q    <= to_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wptr_q[AW-1:0]] <= new_rec;
  end

  assign head = empty ? '0 : mem_q[rptr_q[AW-1:0]];

  assign rec_valid   = ~empty;
  assign rec_kind    = head.kind;
  assign rec_load    = head.load;
  assign rec_inum    = head.inum;
  assign rec_pc      = head.pc;
  assign rec_reg     = head.rd;
  assign rec_a       = head.a;
  assign rec_b       = head.b;
  assign cycle_count = cycle_q;
  assign inst_count  = inst_q;
  assign drop_count  = drop_q;
  assign overflow    = ovf_q;
  assign halted      = halt_q;
  assign timeout     = to_q;
endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;
  localparam int DEPTH = 16;
  localparam int unsigned MAXC = 100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic commit_valid = 0, wb_regwrite = 0, mem_read = 0, mem_write = 0, hlt = 0, rec_ready = 0;
  logic [15:0] commit_pc = '0, wb_data = '0, mem_addr = '0, mem_wdata = '0;
  logic [3:0]  wb_reg_rd = '0;

  logic        rec_valid, rec_load, overflow, halted, timeout;
  logic [1:0]  rec_kind;
  logic [15:0] rec_inum, rec_pc, rec_a, rec_b, drop_count;
  logic [3:0]  rec_reg;
  logic [31:0] cycle_count, inst_count;

  logic        w_valid, w_load, w_overflow, w_halted, w_timeout;
  logic [1:0]  w_kind;
  logic [15:0] w_inum, w_pc, w_a, w_b, w_drop;
  logic [3:0]  w_reg;
  logic [31:0] w_cycle, w_inst;

  always #5 clk = ~clk;

  commit_trace_buffer #(.DEPTH(DEPTH), .MAX_CYCLES(32'd100000)) u_dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .wb_regwrite(wb_regwrite), .wb_reg_rd(wb_reg_rd), .wb_data(wb_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .hlt(hlt), .rec_ready(rec_ready), .rec_valid(rec_valid), .rec_kind(rec_kind),
    .rec_load(rec_load), .rec_inum(rec_inum), .rec_pc(rec_pc), .rec_reg(rec_reg),
    .rec_a(rec_a), .rec_b(rec_b), .cycle_count(cycle_count), .inst_count(inst_count),
    .drop_count(drop_count), .overflow(overflow), .halted(halted), .timeout(timeout));

  // Second instance with a tiny watchdog limit, sharing the same stimulus.
  commit_trace_buffer #(.DEPTH(DEPTH), .MAX_CYCLES(32'd10)) u_wd (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .wb_regwrite(wb_regwrite), .wb_reg_rd(wb_reg_rd), .wb_data(wb_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .hlt(hlt), .rec_ready(rec_ready), .rec_valid(w_valid), .rec_kind(w_kind),
    .rec_load(w_load), .rec_inum(w_inum), .rec_pc(w_pc), .rec_reg(w_reg),
    .rec_a(w_a), .rec_b(w_b), .cycle_count(w_cycle), .inst_count(w_inst),
    .drop_count(w_drop), .overflow(w_overflow), .halted(w_halted), .timeout(w_timeout));

  typedef struct packed {
    logic [1:0]  kind;
    logic        load;
    logic [15:0] inum;
    logic [15:0] pc;
    logic [3:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
  } rec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: records the DUT holds (exp_q) and records pushed this
  // cycle that become visible after the edge (pend_q), plus statistics.
  rec_t exp_q[$];
  rec_t pend_q[$];
  int unsigned m_cyc = 0, m_inst = 0, m_drop = 0;
  bit m_ovf = 0, m_halt = 0, m_to = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: check state against the model, drive this cycle's inputs,
  // then advance the model by what the coming edge should do.
  task automatic tick(input bit r, input bit cv, input logic [15:0] pc, input bit regw,
                      input logic [3:0] rd, input logic [15:0] data, input bit mr,
                      input bit mw, input logic [15:0] addr, input logic [15:0] wd,
                      input bit h, input bit rdy);
    rec_t e;
    int   occ;
    bit   pop;
    @(negedge clk); #1;
    chk("cycle_count", cycle_count, m_cyc);
    chk("inst_count", inst_count, m_inst);
    chk("drop_count", drop_count, m_drop);
    chk("flags", {overflow, halted, timeout}, {m_ovf, m_halt, m_to});
    rst = r; commit_valid = cv; commit_pc = pc; wb_regwrite = regw; wb_reg_rd = rd;
    wb_data = data; mem_read = mr; mem_write = mw; mem_addr = addr; mem_wdata = wd;
    hlt = h; rec_ready = rdy;
    if (r) begin
      exp_q.delete(); pend_q.delete();
      m_cyc = 0; m_inst = 0; m_drop = 0; m_ovf = 0; m_halt = 0; m_to = 0;
    end else if (!m_halt && !m_to) begin
      occ = exp_q.size();
      pop = (occ > 0) && rdy;
      m_cyc++;
      if (m_cyc == MAXC) m_to = 1;
      if (cv) begin
        e = '0;
        e.pc = pc;
        e.inum = m_inst[15:0];
        if (regw) begin
          e.kind = 2'b01; e.load = mr; e.rd = rd; e.a = data; e.b = mr ? addr : 16'h0;
        end else if (h) begin
          e.kind = 2'b11;
        end else if (mw) begin
          e.kind = 2'b10; e.a = addr; e.b = wd;
        end
        m_inst++;
        if (e.kind == 2'b11) m_halt = 1;
        if (occ < DEPTH || pop) pend_q.push_back(e);
        else begin
          if (m_drop < 16'hFFFF) m_drop++;
          m_ovf = 1;
        end
      end
    end
  endtask

  task automatic do_rst();
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input bit rdy);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic rnd(input bit cv, input bit rdy, input bit allow_h);
    tick(0, cv, 16'($urandom), 1'($urandom), 4'($urandom), 16'($urandom), 1'($urandom),
         1'($urandom), 16'($urandom), 16'($urandom), allow_h && ($urandom_range(0, 29) == 0), rdy);
  endtask

  // Monitor: runs late in each cycle once inputs and outputs are stable,
  // compares the head against the model and retires it on a handshake.
  always @(negedge clk) begin
    #3;
    if (!rst) begin
      chk("rec_valid", rec_valid, exp_q.size() != 0);
      if (rec_valid && exp_q.size() != 0) begin
        chk("rec_head", {rec_kind, rec_load, rec_inum, rec_pc, rec_reg, rec_a, rec_b}, exp_q[0]);
        if (rec_ready) void'(exp_q.pop_front());
      end else if (!rec_valid) begin
        chk("rec_empty_zero", {rec_kind, rec_load, rec_inum, rec_pc, rec_reg, rec_a, rec_b}, '0);
      end
      while (pend_q.size() != 0) exp_q.push_back(pend_q.pop_front());
    end
  end

  initial begin
    // Reset and a single REG commit held in the FIFO
    do_rst();
    tick(0, 1, 16'h0000, 1, 4'd3, 16'h1234, 0, 0, 0, 0, 0, 0);
    idle(0);
    chk("reg_kind", rec_kind, 2'b01);
    chk("reg_inum", rec_inum, 0);
    chk("reg_rd_a", {rec_reg, rec_a}, {4'd3, 16'h1234});
    chk("reg_inst", inst_count, 1);

    // Load then store
    do_rst();
    tick(0, 1, 16'h0010, 1, 4'd5, 16'hBEEF, 1, 0, 16'h0040, 0, 0, 0);
    tick(0, 1, 16'h0012, 0, 4'd0, 16'h0, 0, 1, 16'h0042, 16'h00AA, 0, 0);
    idle(0);
    chk("load_rec", {rec_kind, rec_load, rec_a, rec_b}, {2'b01, 1'b1, 16'hBEEF, 16'h0040});
    idle(1);
    idle(0);
    chk("store_rec", {rec_kind, rec_inum, rec_a, rec_b}, {2'b10, 16'd1, 16'h0042, 16'h00AA});
    repeat (2) idle(1);

    // Overflow: 20 commits into 16 entries, then push+pop while full
    do_rst();
    repeat (20) rnd(1, 0, 0);
    idle(0);
    chk("ovf_drop", drop_count, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_inst", inst_count, 20);
    rnd(1, 1, 0);
    idle(0);
    chk("full_pushpop_nodrop", drop_count, 4);
    repeat (20) idle(1);

    // HALT at the third commit; later commits ignored
    do_rst();
    tick(0, 1, 16'h0100, 1, 4'd1, 16'h0001, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 16'h0102, 1, 4'd2, 16'h0002, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 16'h0104, 0, 4'd0, 16'h0000, 0, 0, 0, 0, 1, 0);
    repeat (3) tick(0, 1, 16'h0106, 1, 4'd4, 16'h0004, 0, 0, 0, 0, 0, 0);
    idle(0);
    chk("halt_flag", halted, 1);
    chk("halt_inst", inst_count, 3);
    chk("halt_cyc", cycle_count, 3);
    repeat (5) idle(1);

    // Randomized traffic with occasional halts
    repeat (4) begin
      do_rst();
      repeat (80) rnd(($urandom_range(0, 3) != 0), 1'($urandom), 1);
      repeat (18) idle(1);
    end

    // Watchdog on the MAX_CYCLES=10 instance
    do_rst();
    repeat (14) rnd(1, 1'($urandom), 0);
    chk("wd_timeout", w_timeout, 1);
    chk("wd_cycle", w_cycle, 10);
    chk("wd_inst", w_inst, 10);

    // Reset asserted mid-drain
    do_rst();
    repeat (6) rnd(1, 0, 0);
    repeat (2) idle(1);
    do_rst();
    idle(1);
    chk("rst_mid_valid", rec_valid, 0);
    chk("rst_mid_rec", {rec_kind, rec_load, rec_inum, rec_pc, rec_reg, rec_a, rec_b}, '0);
    chk("rst_mid_cnt", {cycle_count, inst_count, drop_count}, '0);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
